// File: rtl/gpsdo_loop_ctrl.sv
// gpsdo_loop_ctrl: captures 1PPS phase errors, rejects outliers, averages a batch and PI-filters it into the OCXO DAC word.
// Latency: DAC_Update/DAC_Data appear 2 cycles after the capture of the last sample of a batch (CALC registers the result).
// No backpressure: one capture per Meas_Busy fall; losing GPS_Exist drops to holdover with the DAC and integrator frozen.
module gpsdo_loop_ctrl #(
    parameter int AVG_LOG2   = 2,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 0,
    parameter int INT_LIM    = 16384,
    parameter int DAC_MID    = 32768,
    parameter int OUTLIER_TH = 1000,
    parameter int LOCK_TH    = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TUNE_POL   = 0
) (
    input  logic        CLK_Sys,
    input  logic        CLK_Rst,
    input  logic        GPS_Exist,
    input  logic        Meas_Busy,
    input  logic        Meas_Dir,
    input  logic [15:0] Phase_In,
    output logic [15:0] DAC_Data,
    output logic        DAC_Update,
    output logic        Locked,
    output logic        Holdover
);

    localparam int ACC_W = 17 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [LCK_W-1:0]   LCK_FULL = LCK_W'(LOCK_CNT);
    localparam logic [15:0]        OUT_TH16 = 16'(OUTLIER_TH);
    localparam logic signed [31:0] INT_HI   = 32'(INT_LIM);
    localparam logic signed [31:0] INT_LO   = -32'(INT_LIM);
    localparam logic signed [31:0] LCK_HI   = 32'(LOCK_TH);
    localparam logic signed [31:0] LCK_LO   = -32'(LOCK_TH);
    localparam logic signed [31:0] MID32    = 32'(DAC_MID);
    localparam logic signed [31:0] DAC_MAX  = 32'sd65535;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CALC,
        S_OUT
    } state_t;

    state_t                  r_state;
    logic                    r_busy_d;
    logic                    r_cap_pend;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [31:0]      r_integ;
    logic [LCK_W-1:0]        r_lock_cnt;
    logic [15:0]             r_dac;
    logic                    r_dac_upd;
    logic                    r_locked;
    logic                    r_holdover;

    logic                    w_fall;
    logic                    w_cap;
    logic signed [16:0]      w_err;
    logic signed [ACC_W-1:0] w_err_ext;
    logic signed [16:0]      w_avg;
    logic signed [31:0]      w_avg32;
    logic signed [31:0]      w_integ_sum;
    logic signed [31:0]      w_integ_nxt;
    logic signed [31:0]      w_raw;
    logic [15:0]             w_dac_sat;
    logic                    w_in_lock;
    logic [LCK_W-1:0]        w_lock_nxt;

    // A capture is the cycle after the fall; outliers never become captures.
    assign w_fall = r_busy_d & ~Meas_Busy;
    assign w_cap  = r_cap_pend & (Phase_In <= OUT_TH16);

    // Register Meas_Busy for edge detection and delay the fall by one cycle so Phase_In has settled.
    always_ff @(posedge CLK_Sys) begin
        if (CLK_Rst) begin
            r_busy_d   <= 1'b0;
            r_cap_pend <= 1'b0;
        end else begin
            r_busy_d   <= Meas_Busy;
            r_cap_pend <= w_fall;
        end
    end

    // Signed phase error with direction and tuning polarity applied.
    always_comb begin
        w_err = Meas_Dir ? -$signed({1'b0, Phase_In}) : $signed({1'b0, Phase_In});
        if (TUNE_POL != 0) begin
            w_err = -w_err;
        end
    end

    // Average is the accumulator with the low bits dropped, i.e. an arithmetic floor shift.
    assign w_err_ext = {{AVG_LOG2{w_err[16]}}, w_err};
    assign w_avg     = r_acc[ACC_W-1:AVG_LOG2];
    assign w_avg32   = {{15{w_avg[16]}}, w_avg};

    // Clamped integrator update and saturated tuning word, both from the current batch average.
    always_comb begin
        w_integ_sum = r_integ + (w_avg32 <<< KI_SHIFT);
        if (w_integ_sum > INT_HI) begin
            w_integ_nxt = INT_HI;
        end else if (w_integ_sum < INT_LO) begin
            w_integ_nxt = INT_LO;
        end else begin
            w_integ_nxt = w_integ_sum;
        end
        w_raw = MID32 + (w_avg32 <<< KP_SHIFT) + w_integ_nxt;
        if (w_raw < 0) begin
            w_dac_sat = 16'd0;
        end else if (w_raw > DAC_MAX) begin
            w_dac_sat = 16'hFFFF;
        end else begin
            w_dac_sat = w_raw[15:0];
        end
    end

    // Lock counter: saturates at LOCK_CNT while the average stays in threshold, clears otherwise.
    always_comb begin
        w_in_lock = (w_avg32 <= LCK_HI) && (w_avg32 >= LCK_LO);
        if (!w_in_lock) begin
            w_lock_nxt = '0;
        end else if (r_lock_cnt == LCK_FULL) begin
            w_lock_nxt = r_lock_cnt;
        end else begin
            w_lock_nxt = r_lock_cnt + 1'b1;
        end
    end

    // Loop state machine: collect a batch, compute and publish the new tuning word, fall back to holdover on GPS loss.
    always_ff @(posedge CLK_Sys) begin
        if (CLK_Rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_integ    <= '0;
            r_lock_cnt <= '0;
            r_dac      <= 16'(DAC_MID);
            r_dac_upd  <= 1'b0;
            r_locked   <= 1'b0;
            r_holdover <= 1'b1;
        end else begin
            r_dac_upd <= 1'b0;
            if (!GPS_Exist) begin
                // Integrator and DAC word are deliberately left untouched here.
                r_state    <= S_IDLE;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
                r_holdover <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_holdover <= 1'b0;
                        r_state    <= S_COLLECT;
                    end
                    S_COLLECT: begin
                        r_holdover <= 1'b0;
                        if (w_cap) begin
                            r_acc <= r_acc + w_err_ext;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_LAST) begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_integ    <= w_integ_nxt;
                        r_dac      <= w_dac_sat;
                        r_dac_upd  <= 1'b1;
                        r_lock_cnt <= w_lock_nxt;
                        r_locked   <= (w_lock_nxt == LCK_FULL);
                        // The batch is consumed here; a coincident capture seeds the next batch.
                        if (w_cap) begin
                            r_acc <= w_err_ext;
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                        r_state <= S_OUT;
                    end
                    S_OUT: begin
                        if (w_cap) begin
                            r_acc <= r_acc + w_err_ext;
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_state <= S_COLLECT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign DAC_Data   = r_dac;
    assign DAC_Update = r_dac_upd;
    assign Locked     = r_locked;
    assign Holdover   = r_holdover;

endmodule

// File: tb/tb_gpsdo_loop_ctrl.sv
// tb_gpsdo_loop_ctrl: directed measurements with hand-computed DAC words queued at issue time.
// A negedge monitor pops the queue on every DAC_Update and checks value and arrival cycle.
// Static outputs (reset, holdover, lock) are checked inline by the stimulus process.
module tb_gpsdo_loop_ctrl;

    logic        CLK_Sys;
    logic        CLK_Rst;
    logic        GPS_Exist;
    logic        Meas_Busy;
    logic        Meas_Dir;
    logic [15:0] Phase_In;
    logic [15:0] DAC_Data;
    logic        DAC_Update;
    logic        Locked;
    logic        Holdover;

    int          n_checks;
    int          n_fail;
    int          cyc;
    string       test_name;
    logic [15:0] exp_val_q[$];
    int          exp_cyc_q[$];

    gpsdo_loop_ctrl dut (
        .CLK_Sys    (CLK_Sys),
        .CLK_Rst    (CLK_Rst),
        .GPS_Exist  (GPS_Exist),
        .Meas_Busy  (Meas_Busy),
        .Meas_Dir   (Meas_Dir),
        .Phase_In   (Phase_In),
        .DAC_Data   (DAC_Data),
        .DAC_Update (DAC_Update),
        .Locked     (Locked),
        .Holdover   (Holdover)
    );

    initial CLK_Sys = 1'b0;
    always #50 CLK_Sys = ~CLK_Sys;

    initial cyc = 0;
    always @(posedge CLK_Sys) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", test_name, name, act, exp_v);
        end
    endtask

    // Monitor: every DAC_Update must match the oldest queued expectation.
    always @(negedge CLK_Sys) begin
        if (DAC_Update === 1'b1) begin
            if (exp_val_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s/unexpected_update: got DAC_Data=%0d at cycle %0d, expected no update", test_name, DAC_Data, cyc);
            end else begin
                chk("dac_data", int'(DAC_Data), int'(exp_val_q.pop_front()));
                chk("update_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // One measurement: Busy high for a cycle, then low with the result presented.
    task automatic meas(input logic [15:0] ph, input logic dir, input bit upd, input int exp_v, input int gap);
        @(negedge CLK_Sys);
        Meas_Busy = 1'b1;
        @(negedge CLK_Sys);
        Meas_Busy = 1'b0;
        Phase_In  = ph;
        Meas_Dir  = dir;
        if (upd) begin
            exp_val_q.push_back(16'(exp_v));
            exp_cyc_q.push_back(cyc + 3);
        end
        repeat (gap) @(negedge CLK_Sys);
    endtask

    task automatic batch(input logic [15:0] ph, input logic dir, input int exp_v);
        repeat (3) meas(ph, dir, 1'b0, 0, 3);
        meas(ph, dir, 1'b1, exp_v, 3);
    endtask

    task automatic drain();
        repeat (6) @(negedge CLK_Sys);
        chk("pending_updates", exp_val_q.size(), 0);
        exp_val_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK_Sys);
        CLK_Rst = 1'b1;
        @(negedge CLK_Sys);
        chk("rst_dac", int'(DAC_Data), 32768);
        chk("rst_holdover", int'(Holdover), 1);
        chk("rst_locked", int'(Locked), 0);
        chk("rst_update", int'(DAC_Update), 0);
        CLK_Rst = 1'b0;
    endtask

    initial begin
        int lim;
        n_checks  = 0;
        n_fail    = 0;
        CLK_Rst   = 1'b1;
        GPS_Exist = 1'b0;
        Meas_Busy = 1'b0;
        Meas_Dir  = 1'b0;
        Phase_In  = 16'd0;

        // Reset, then release with no GPS: nothing may move.
        test_name = "reset";
        repeat (3) @(negedge CLK_Sys);
        chk("dac", int'(DAC_Data), 32768);
        chk("holdover", int'(Holdover), 1);
        chk("locked", int'(Locked), 0);
        chk("update", int'(DAC_Update), 0);
        CLK_Rst = 1'b0;
        repeat (10) @(negedge CLK_Sys);
        meas(16'd10, 1'b0, 1'b0, 0, 3);
        chk("idle_dac", int'(DAC_Data), 32768);
        chk("idle_holdover", int'(Holdover), 1);
        chk("idle_locked", int'(Locked), 0);
        drain();

        // Two identical positive batches: proportional 40, integrator 10 then 20.
        test_name = "basic";
        GPS_Exist = 1'b1;
        repeat (2) @(negedge CLK_Sys);
        chk("holdover", int'(Holdover), 0);
        batch(16'd10, 1'b0, 32818);
        batch(16'd10, 1'b0, 32828);
        chk("locked", int'(Locked), 0);
        drain();

        // GPS lags: negative error lowers the DAC.
        test_name = "negative";
        do_reset();
        batch(16'd10, 1'b1, 32718);
        drain();

        // A 5000 outlier is skipped without being counted.
        test_name = "outlier";
        do_reset();
        meas(16'd10, 1'b0, 1'b0, 0, 3);
        meas(16'd5000, 1'b0, 1'b0, 0, 3);
        meas(16'd10, 1'b0, 1'b0, 0, 3);
        meas(16'd10, 1'b0, 1'b0, 0, 3);
        meas(16'd10, 1'b0, 1'b1, 32818, 3);
        drain();

        // 1000 accepted, 1001 rejected; sum -1 floors to average -1 -> 32768-4-1.
        test_name = "floor_edge";
        do_reset();
        meas(16'd1000, 1'b1, 1'b0, 0, 3);
        meas(16'd1001, 1'b0, 1'b0, 0, 3);
        meas(16'd1000, 1'b0, 1'b0, 0, 3);
        meas(16'd1, 1'b1, 1'b0, 0, 3);
        meas(16'd0, 1'b0, 1'b1, 32763, 3);
        drain();

        // Next capture lands during OUT and must count as sample 1 of the next batch.
        test_name = "overlap";
        repeat (3) meas(16'd10, 1'b0, 1'b0, 0, 3);
        meas(16'd10, 1'b0, 1'b1, 32817, 0);
        meas(16'd20, 1'b0, 1'b0, 0, 3);
        meas(16'd20, 1'b0, 1'b0, 0, 3);
        meas(16'd20, 1'b0, 1'b0, 0, 3);
        meas(16'd20, 1'b0, 1'b1, 32877, 3);
        drain();

        // Integrator clamps at +16384: final word 32768+3996+16384.
        test_name = "sat_hi";
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            lim = 999 * k;
            if (lim > 16384) lim = 16384;
            batch(16'd999, 1'b0, 36764 + lim);
        end
        chk("final_dac", int'(DAC_Data), 53148);
        drain();

        // Mirror: clamps at -16384, final word 32768-3996-16384.
        test_name = "sat_lo";
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            lim = 999 * k;
            if (lim > 16384) lim = 16384;
            batch(16'd999, 1'b1, 28772 - lim);
        end
        chk("final_dac", int'(DAC_Data), 12388);
        drain();

        // Lock: avg -2 (on threshold) then three zero batches; Locked rises right after the 4th CALC.
        test_name = "lock";
        do_reset();
        batch(16'd2, 1'b1, 32758);
        chk("locked_1", int'(Locked), 0);
        batch(16'd0, 1'b0, 32766);
        batch(16'd0, 1'b0, 32766);
        chk("locked_3", int'(Locked), 0);
        repeat (3) meas(16'd0, 1'b0, 1'b0, 0, 3);
        meas(16'd0, 1'b0, 1'b1, 32766, 0);
        repeat (2) @(negedge CLK_Sys);
        chk("locked_before_calc", int'(Locked), 0);
        @(negedge CLK_Sys);
        chk("locked_after_calc", int'(Locked), 1);
        repeat (3) @(negedge CLK_Sys);
        batch(16'd5, 1'b0, 32791);
        chk("unlock_avg5", int'(Locked), 0);
        repeat (4) batch(16'd0, 1'b0, 32771);
        chk("relock", int'(Locked), 1);
        drain();

        // GPS loss mid-batch: freeze, drop lock, discard the partial batch, keep the integrator.
        test_name = "holdover";
        meas(16'd100, 1'b0, 1'b0, 0, 3);
        meas(16'd100, 1'b0, 1'b0, 0, 3);
        GPS_Exist = 1'b0;
        @(negedge CLK_Sys);
        chk("holdover", int'(Holdover), 1);
        chk("locked", int'(Locked), 0);
        chk("dac_frozen", int'(DAC_Data), 32771);
        meas(16'd50, 1'b0, 1'b0, 0, 3);
        repeat (5) @(negedge CLK_Sys);
        chk("dac_still_frozen", int'(DAC_Data), 32771);
        chk("holdover_still", int'(Holdover), 1);
        GPS_Exist = 1'b1;
        repeat (2) @(negedge CLK_Sys);
        chk("holdover_cleared", int'(Holdover), 0);
        batch(16'd8, 1'b0, 32811);
        chk("locked_after", int'(Locked), 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
